// File: rtl/ptcalc_ap_sequencer.sv
// ptcalc_ap_sequencer: ap_ctrl_hs initiator that collects a candidate plus segment words, launches the HLS pT core and forwards its result.
// Optional debug ports (latency, ptcalc snapshot, idle check) are enabled by defining PTCALC_SEQ_DEBUG_EN.
module ptcalc_ap_sequencer #(
    parameter int PL_W    = 64,
    parameter int SF_W    = 32,
    parameter int MTC_W   = 48,
    parameter int WINDOW  = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [PL_W-1:0]  pl_i_data,
    input  logic             pl_i_valid,
    input  logic             pl_i_is_c_side,
    input  logic [SF_W-1:0]  sf_inn_i_data,
    input  logic             sf_inn_i_valid,
    input  logic [SF_W-1:0]  sf_mid_i_data,
    input  logic             sf_mid_i_valid,
    input  logic [SF_W-1:0]  sf_out_i_data,
    input  logic             sf_out_i_valid,
    output logic [MTC_W-1:0] mtc_o_data,
    output logic             mtc_o_valid,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [15:0]      drop_cnt_o,
    output logic             core_ap_start,
    input  logic             core_ap_done,
    input  logic             core_ap_idle,
    input  logic             core_ap_ready,
    output logic [PL_W-1:0]  core_pl2ptcalc,
    output logic [SF_W-1:0]  core_sf2ptcalc_inn,
    output logic [SF_W-1:0]  core_sf2ptcalc_mid,
    output logic [SF_W-1:0]  core_sf2ptcalc_out,
    output logic             core_is_C_side,
`ifdef PTCALC_SEQ_DEBUG_EN
    output logic [15:0]      dbg_latency_o,
    input  logic [57:0]      dbg_ptcalc_i,
    output logic [57:0]      dbg_ptcalc_o,
    output logic             dbg_idle_err_o,
`endif
    input  logic [MTC_W-1:0] core_ptcalc2mtc,
    input  logic             core_ptcalc2mtc_ap_vld
);
    localparam int WW = WINDOW > 1 ? $clog2(WINDOW) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, START, WAIT} state_t;

    state_t           state_q;
    logic [2:0]       pres_q;
    logic [WW-1:0]    win_q;
    logic [TW-1:0]    wait_q;
    logic [PL_W-1:0]  pl_q;
    logic             c_q;
    logic [SF_W-1:0]  inn_q, mid_q, out_q;
    logic             start_q, mtc_vld_q, to_q;
    logic [MTC_W-1:0] mtc_q;
    logic [15:0]      drop_q;
    logic [2:0]       sf_v;
    logic             enough, collect_end, launch, drop_d;

    assign sf_v = {sf_out_i_valid, sf_mid_i_valid, sf_inn_i_valid};
    assign enough = (pres_q[0] & pres_q[1]) | (pres_q[0] & pres_q[2]) | (pres_q[1] & pres_q[2]);
    // Exit decision uses registered presence; words arriving on the exit cycle are not captured
    assign collect_end = state_q == COLLECT && (&pres_q || win_q == WIN_LAST);
    assign launch = collect_end && enough;
    assign drop_d = (pl_i_valid && state_q != IDLE) || (collect_end && !enough);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            pres_q    <= '0;
            win_q     <= '0;
            wait_q    <= '0;
            pl_q      <= '0;
            c_q       <= 1'b0;
            inn_q     <= '0;
            mid_q     <= '0;
            out_q     <= '0;
            start_q   <= 1'b0;
            mtc_vld_q <= 1'b0;
            to_q      <= 1'b0;
            mtc_q     <= '0;
            drop_q    <= '0;
        end else begin
            mtc_vld_q <= 1'b0;
            to_q      <= 1'b0;
            if (drop_d && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            unique case (state_q)
                IDLE: if (pl_i_valid) begin
                    pl_q    <= pl_i_data;
                    c_q     <= pl_i_is_c_side;
                    inn_q   <= sf_inn_i_valid ? sf_inn_i_data : '0;
                    mid_q   <= sf_mid_i_valid ? sf_mid_i_data : '0;
                    out_q   <= sf_out_i_valid ? sf_out_i_data : '0;
                    pres_q  <= sf_v;
                    win_q   <= '0;
                    state_q <= COLLECT;
                end
                COLLECT: begin
                    win_q <= win_q + 1'b1;
                    if (collect_end) begin
                        state_q <= launch ? START : IDLE;
                        start_q <= launch;
                    end else begin
                        if (sf_inn_i_valid && !pres_q[0]) inn_q <= sf_inn_i_data;
                        if (sf_mid_i_valid && !pres_q[1]) mid_q <= sf_mid_i_data;
                        if (sf_out_i_valid && !pres_q[2]) out_q <= sf_out_i_data;
                        pres_q <= pres_q | sf_v;
                    end
                end
                START: if (core_ap_ready) begin
                    start_q <= 1'b0;
                    wait_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (core_ptcalc2mtc_ap_vld) begin
                        mtc_q     <= core_ptcalc2mtc;
                        mtc_vld_q <= 1'b1;
                    end
                    if (core_ap_done) state_q <= IDLE;
                    else if (wait_q == TO_LAST) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mtc_o_data         = mtc_q;
    assign mtc_o_valid        = mtc_vld_q;
    assign busy_o             = state_q != IDLE;
    assign timeout_o          = to_q;
    assign drop_cnt_o         = drop_q;
    assign core_ap_start      = start_q;
    assign core_pl2ptcalc     = pl_q;
    assign core_sf2ptcalc_inn = inn_q;
    assign core_sf2ptcalc_mid = mid_q;
    assign core_sf2ptcalc_out = out_q;
    assign core_is_C_side     = c_q;

`ifdef PTCALC_SEQ_DEBUG_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [15:0]   lat_q, dbg_lat_q;
    logic [57:0]   dbg_pt_q;
    logic [IW-1:0] idle_q;
    logic          idle_err_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            lat_q      <= '0;
            dbg_lat_q  <= '0;
            dbg_pt_q   <= '0;
            idle_q     <= '0;
            idle_err_q <= 1'b0;
        end else begin
            if (launch) lat_q <= 16'd1;
            else if ((state_q == START || state_q == WAIT) && lat_q != 16'hFFFF) lat_q <= lat_q + 16'd1;
            if (state_q == WAIT && core_ap_done) begin
                dbg_lat_q <= lat_q;
                dbg_pt_q  <= dbg_ptcalc_i;
            end
            if (state_q == IDLE && !core_ap_idle) begin
                if (idle_q == IW'(TIMEOUT)) idle_err_q <= 1'b1;
                else idle_q <= idle_q + 1'b1;
            end else idle_q <= '0;
        end
    end

    assign dbg_latency_o  = dbg_lat_q;
    assign dbg_ptcalc_o   = dbg_pt_q;
    assign dbg_idle_err_o = idle_err_q;
`else
    logic unused_idle;
    assign unused_idle = core_ap_idle;
`endif
endmodule
